digital_pll_trim_nco: RTL and testbench

Synthesizable digitally-trimmed oscillator that sits on the far side of the digital_pll_controller trim bus.
- Consumes the 26-bit trim word and produces the `osc` signal that the controller measures, closing the PLL loop in simulation and FPGA builds.
- Trim is decoded to a delay level; a half-period counter toggles `osc`.
- Higher trim means a longer period, i.e. a slower oscillator.

---
 rtl/digital_pll_pkg.sv | 34 +++
 rtl/digital_pll_trim_decode.sv | 21 ++
 rtl/digital_pll_trim_nco.sv | 76 +++++++
 tb/tb_digital_pll_trim_nco.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/digital_pll_pkg.sv
// Shared constants, types and helpers for the digital PLL trim bus.
// is_thermo() is also reused by the controller bench.
package digital_pll_pkg;

  localparam int TRIM_W         = 26;
  localparam int TRIM_HALF_W    = 13;
  localparam int LEVEL_W        = 5;
  localparam int TRIM_MAX_LEVEL = 26;

  typedef logic [TRIM_W-1:0]      trim_t;
  typedef logic [TRIM_HALF_W-1:0] trim_half_t;
  typedef logic [LEVEL_W-1:0]     level_t;

  // Valid thermometer half: contiguous ones from bit 0 upward, all-zero allowed.
  function automatic logic is_thermo(input trim_half_t v);
    logic ok;
    logic seen_zero;
    ok        = 1'b1;
    seen_zero = 1'b0;
    for (int i = 0; i < TRIM_HALF_W; i++) begin
      if (!v[i]) seen_zero = 1'b1;
      else if (seen_zero) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic level_t popcount(input trim_t v);
    level_t c;
    c = '0;
    for (int i = 0; i < TRIM_W; i++) c = c + level_t'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/digital_pll_trim_decode.sv
// Combinational trim decoder: popcount level plus thermometer validity.
// Validity logic is generated only under DIGITAL_PLL_TRIM_CODE_CHECK_EN.
module digital_pll_trim_decode
  import digital_pll_pkg::*;
(
  input  logic [TRIM_W-1:0]  trim,
  output logic [LEVEL_W-1:0] level,
  output logic               thermo_ok
);

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    level = popcount(trim);
`ifdef DIGITAL_PLL_TRIM_CODE_CHECK_EN
    thermo_ok = is_thermo(trim[TRIM_HALF_W-1:0]) && is_thermo(trim[TRIM_W-1:TRIM_HALF_W]);
`else
    thermo_ok = 1'b1;
`endif
  end

endmodule

// File: rtl/digital_pll_trim_nco.sv
// Digitally trimmed oscillator: trim popcount sets the half-period of osc.
// Optional trim code check enabled by DIGITAL_PLL_TRIM_CODE_CHECK_EN.
module digital_pll_trim_nco
  import digital_pll_pkg::*;
#(
  parameter int MIN_HALF  = 4,
  parameter int STEP_HALF = 1,
  parameter int HP_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [TRIM_W-1:0]  trim,
  output logic               osc,
  output logic               osc_rise,
  output logic [LEVEL_W-1:0] trim_level,
  output logic               code_err
);

  if (longint'(MIN_HALF) + longint'(TRIM_MAX_LEVEL) * longint'(STEP_HALF)
      > (longint'(1) << HP_W) - 1) begin : g_hp_w_too_small
    $error("HP_W too narrow for MIN_HALF + 26*STEP_HALF");
  end

  logic [LEVEL_W-1:0] dec_level;
  logic               thermo_ok;
  logic [HP_W-1:0]    half_in;
  logic [HP_W-1:0]    cnt;
  logic               load;

  digital_pll_trim_decode u_decode (
    .trim      (trim),
    .level     (dec_level),
    .thermo_ok (thermo_ok)
  );

  // The incoming trim only matters at a retune point or while disabled.
  assign half_in = HP_W'(MIN_HALF) + HP_W'(dec_level) * HP_W'(STEP_HALF);
  assign load    = !enable || (cnt == '0);

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      osc        <= 1'b0;
      osc_rise   <= 1'b0;
      trim_level <= '0;
      cnt        <= HP_W'(MIN_HALF - 1);
    end else if (!enable) begin
      osc        <= 1'b0;
      osc_rise   <= 1'b0;
      trim_level <= dec_level;
      cnt        <= half_in - 1'b1;
    end else if (cnt == '0) begin
      osc        <= ~osc;
      osc_rise   <= ~osc;
      trim_level <= dec_level;
      cnt        <= half_in - 1'b1;
    end else begin
      osc_rise   <= 1'b0;
      cnt        <= cnt - 1'b1;
    end
  end

`ifdef DIGITAL_PLL_TRIM_CODE_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     code_err <= 1'b0;
    else if (load) code_err <= ~thermo_ok;
  end
`else
  // The decoder reports a constant valid code here, so this folds to 0.
  assign code_err = ~thermo_ok;
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_digital_pll_trim_nco.sv
// Self-checking bench for digital_pll_trim_nco: directed phase measurements
// plus randomized trim/enable/reset against a phase-length reference model.
module tb_digital_pll_trim_nco;

  localparam int MIN_HALF  = 4;
  localparam int STEP_HALF = 1;
  localparam int HP_W      = 16;
`ifdef DIGITAL_PLL_TRIM_CODE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [25:0] trim = '0;
  logic        osc, osc_rise, code_err;
  logic [4:0]  trim_level;

  int checks = 0;
  int errors = 0;

  digital_pll_trim_nco #(.MIN_HALF(MIN_HALF), .STEP_HALF(STEP_HALF), .HP_W(HP_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .trim       (trim),
    .osc        (osc),
    .osc_rise   (osc_rise),
    .trim_level (trim_level),
    .code_err   (code_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: phase length = MIN_HALF + popcount(trim)*STEP_HALF, counted in whole cycles.
  function automatic int half_of(input logic [25:0] t);
    return MIN_HALF + $countones(t) * STEP_HALF;
  endfunction

  function automatic bit half_bad(input logic [12:0] h);
    logic [13:0] full;
    full = (14'd1 << $countones(h)) - 14'd1;
    return {1'b0, h} != full;
  endfunction

  function automatic bit code_bad(input logic [25:0] t);
    return CHECK_EN && (half_bad(t[12:0]) || half_bad(t[25:13]));
  endfunction

  bit m_osc, m_rise, m_err;
  int m_lvl, m_rem;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_osc  <= 1'b0;
      m_rise <= 1'b0;
      m_lvl  <= 0;
      m_err  <= 1'b0;
      m_rem  <= MIN_HALF;
    end else if (!enable) begin
      m_osc  <= 1'b0;
      m_rise <= 1'b0;
      m_lvl  <= $countones(trim);
      m_err  <= code_bad(trim);
      m_rem  <= half_of(trim);
    end else if (m_rem == 1) begin
      m_osc  <= !m_osc;
      m_rise <= !m_osc;
      m_lvl  <= $countones(trim);
      m_err  <= code_bad(trim);
      m_rem  <= half_of(trim);
    end else begin
      m_rise <= 1'b0;
      m_rem  <= m_rem - 1;
    end
  end

  bit prev_rise = 1'b0;
  always @(negedge clock) begin
    check("osc", osc, m_osc);
    check("osc_rise", osc_rise, m_rise);
    check("trim_level", trim_level, m_lvl);
    check("code_err", code_err, m_err);
    check("rise_single", osc_rise & prev_rise, 0);
    prev_rise = osc_rise;
  end

  // Count sampled cycles until osc differs from its current value.
  task automatic wait_change(output int n);
    logic start;
    start = osc;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (osc === start && n < 200);
    if (osc === start) check("wait_timeout", n, -1);
  endtask

  task automatic sync_rise();
    int n;
    int tries;
    tries = 0;
    do begin
      wait_change(n);
      tries++;
    end while (osc !== 1'b1 && tries < 4);
    check("sync_rise", osc, 1);
  endtask

  function automatic logic [25:0] rand_trim();
    logic [25:0] t;
    int a, b;
    if ($urandom_range(0, 1) == 0) begin
      t = 26'($urandom());
    end else begin
      a = $urandom_range(0, 13);
      b = $urandom_range(0, 13);
      t = {13'((14'd1 << b) - 14'd1), 13'((14'd1 << a) - 14'd1)};
    end
    return t;
  endfunction

  initial begin
    int n;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_osc", osc, 0);
    check("rst_level", trim_level, 0);
    reset = 1'b0;

    // Default period: first rise 4 cycles after release, then 4/4.
    wait_change(n); check("first_rise", n, 4);
    wait_change(n); check("high_t0", n, 4);
    wait_change(n); check("low_t0", n, 4);

    // Saturated trim.
    trim = 26'h3FFFFFF;
    wait_change(n);
    wait_change(n); check("phase_sat_a", n, 30);
    check("level_sat", trim_level, 26);
    wait_change(n); check("phase_sat_b", n, 30);

    // Mid-phase retune has no effect until the next toggle.
    trim = '0;
    sync_rise();
    sync_rise();
    repeat (2) @(negedge clock);
    trim = 26'h0001FFF;
    wait_change(n); check("mid_high", n + 2, 4);
    wait_change(n); check("low_l13", n, 17);
    check("level_l13", trim_level, 13);

    // Enable dropped while high, then re-enable with a new trim.
    sync_rise();
    @(negedge clock); enable = 1'b0;
    @(negedge clock);
    check("dis_osc", osc, 0);
    check("dis_rise", osc_rise, 0);
    trim = 26'h0000007;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    wait_change(n); check("reen_low", n, 7);

    // Reset mid-phase with level 13 latched.
    trim = 26'h0001FFF;
    wait_change(n); wait_change(n);
    check("pre_rst_level", trim_level, 13);
    @(negedge clock); #2 reset = 1'b1;
    #1;
    check("async_osc", osc, 0);
    check("async_level", trim_level, 0);
    @(negedge clock); reset = 1'b0;
    wait_change(n); check("rst_first", n, 4);
    wait_change(n); check("rst_phase", n, 17);

    // Thermometer code check.
    trim = 26'h0000005;
    wait_change(n); wait_change(n);
    check("err_bad", code_err, int'(CHECK_EN));
    check("level_bad", trim_level, 2);
    trim = 26'h0000007;
    wait_change(n); wait_change(n);
    check("err_good", code_err, 0);
    check("level_good", trim_level, 3);

    // Randomized trim, enable and reset against the reference model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if ($urandom_range(0, 99) < 6) trim = rand_trim();
      enable = ($urandom_range(0, 99) < 96);
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
